gate_mode_controller: RTL and testbench



---
 rtl/gate_ctrl_pkg.sv | 33 +++
 rtl/button_debouncer.sv | 41 ++++
 rtl/gate_mode_controller.sv | 113 +++++++++++
 tb/tb_gate_mode_controller.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/gate_ctrl_pkg.sv
// rtl/gate_ctrl_pkg.sv - shared encodings for the gate mode controller
package gate_ctrl_pkg;

  // Gate function codes; 6 and 7 are never produced by stepping
  localparam logic [2:0] MODE_AND  = 3'd0;
  localparam logic [2:0] MODE_OR   = 3'd1;
  localparam logic [2:0] MODE_XOR  = 3'd2;
  localparam logic [2:0] MODE_NAND = 3'd3;
  localparam logic [2:0] MODE_NOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;
  localparam logic [2:0] MODE_LAST = MODE_XNOR;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SWEEP  = 1'b1
  } state_t;

  // Button bit positions
  localparam int BTN_A    = 0;
  localparam int BTN_B    = 1;
  localparam int BTN_MODE = 2;
  localparam int BTN_DEMO = 3;

  // LED bit positions
  localparam int LED_RESULT   = 0;
  localparam int LED_MODE_LSB = 1;
  localparam int LED_MODE_MSB = 3;
  localparam int LED_OP_A     = 4;
  localparam int LED_OP_B     = 5;
  localparam int LED_SWEEP    = 6;
  localparam int LED_MARK     = 7;

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchronizer, stability counter and rise detect for one button
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic raw,
  output logic debounced,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;

  // Synchronize, then accept a new level only after it has differed for DEBOUNCE_CYCLES samples;
  // the rise pulse is aligned with the cycle the debounced level goes high
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q    <= 2'b00;
      debounced <= 1'b0;
      rise      <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
      rise   <= 1'b0;
      if (sync_q[1] == debounced) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        debounced <= sync_q[1];
        rise      <= sync_q[1];
        cnt       <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/gate_mode_controller.sv
// rtl/gate_mode_controller.sv - button-driven gate mode selector with automatic operand sweep
module gate_mode_controller
  import gate_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] BTN,
  output logic [7:0] LED
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [3:0]    btn_db;
  logic [3:0]    btn_rise;
  state_t        state;
  logic [2:0]    mode;
  logic [1:0]    op_cnt;
  logic [HW-1:0] hold;
  logic          marker;
  logic [1:0]    operands;
  logic          result;
  logic          unused_btn;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .CLK      (CLK),
      .RESET    (RESET),
      .raw      (BTN[i]),
      .debounced(btn_db[i]),
      .rise     (btn_rise[i])
    );
  end

  // Operand buttons have no rise use; mode/demo buttons have no level use
  assign unused_btn = ^{btn_rise[BTN_B:BTN_A], btn_db[BTN_DEMO:BTN_MODE]};

  // Operands come from the buttons in MANUAL and from the sweep counter in SWEEP
  always_comb begin
    operands = btn_db[BTN_B:BTN_A];
    if (state == ST_SWEEP) begin
      operands = op_cnt;
    end
  end

  // Gate function selected by mode; unreachable codes yield 0
  always_comb begin
    result = 1'b0;
    case (mode)
      MODE_AND:  result =   operands[0] & operands[1];
      MODE_OR:   result =   operands[0] | operands[1];
      MODE_XOR:  result =   operands[0] ^ operands[1];
      MODE_NAND: result = ~(operands[0] & operands[1]);
      MODE_NOR:  result = ~(operands[0] | operands[1]);
      MODE_XNOR: result = ~(operands[0] ^ operands[1]);
      default:   result = 1'b0;
    endcase
  end

  // Mode stepping, MANUAL/SWEEP sequencing and the LED register (shows state one cycle late)
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= ST_MANUAL;
      mode   <= MODE_AND;
      op_cnt <= 2'd0;
      hold   <= '0;
      marker <= 1'b0;
      LED    <= 8'h00;
    end else begin
      if (btn_rise[BTN_MODE]) begin
        mode   <= (mode >= MODE_LAST) ? MODE_AND : mode + 3'd1;
        marker <= ~marker;
      end

      case (state)
        ST_MANUAL: begin
          if (btn_rise[BTN_DEMO]) begin
            state  <= ST_SWEEP;
            op_cnt <= 2'd0;
            hold   <= '0;
          end
        end
        ST_SWEEP: begin
          if (hold == HOLD_LAST) begin
            hold <= '0;
            if (op_cnt == 2'd3) begin
              state  <= ST_MANUAL;
              op_cnt <= 2'd0;
            end else begin
              op_cnt <= op_cnt + 2'd1;
            end
          end else begin
            hold <= hold + HW'(1);
          end
        end
        default: state <= ST_MANUAL;
      endcase

      LED[LED_RESULT]                <= result;
      LED[LED_MODE_MSB:LED_MODE_LSB] <= mode;
      LED[LED_OP_A]                  <= operands[0];
      LED[LED_OP_B]                  <= operands[1];
      LED[LED_SWEEP]                 <= (state == ST_SWEEP);
      LED[LED_MARK]                  <= marker;
    end
  end

endmodule

// File: tb/tb_gate_mode_controller.sv
// tb/tb_gate_mode_controller.sv - directed table plus randomized checking of gate_mode_controller
module tb_gate_mode_controller;

  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] BTN   = 4'h0;
  logic [7:0] LED;

  gate_mode_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .BTN  (BTN),
    .LED  (LED)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    int         ncyc;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Reference model state
  logic [3:0] m_r1, m_r2, m_db, m_rise;
  bit         win[4][$];
  int         m_steps;
  bit         m_sweep;
  int         m_age;
  logic [7:0] m_led;

  function automatic bit gate_ref(input int mode, input bit a, input bit b);
    int s;
    s = int'(a) + int'(b);
    case (mode)
      0: return s == 2;
      1: return s >= 1;
      2: return s == 1;
      3: return s < 2;
      4: return s == 0;
      5: return s != 1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_r1 = 0; m_r2 = 0; m_db = 0; m_rise = 0;
    m_steps = 0; m_sweep = 0; m_age = 0; m_led = 8'h00;
    for (int b = 0; b < 4; b++) win[b].delete();
  endtask

  task automatic model_edge(input logic rst, input logic [3:0] btn);
    logic [1:0] ops;
    logic [3:0] nrise;
    int         mode;
    bit         all_diff;
    if (rst) begin
      model_reset();
    end else begin
      mode  = m_steps % 6;
      ops   = m_sweep ? 2'(m_age / HOLD) : m_db[1:0];
      m_led = {1'(m_steps % 2), m_sweep, ops, 3'(mode), gate_ref(mode, ops[0], ops[1])};
      if (m_sweep) begin
        m_age++;
        if (m_age == 4 * HOLD) m_sweep = 0;
      end else if (m_rise[3]) begin
        m_sweep = 1;
        m_age   = 0;
      end
      if (m_rise[2]) m_steps++;
      nrise = 4'h0;
      for (int b = 0; b < 4; b++) begin
        win[b].push_back(m_r2[b]);
        if (win[b].size() > DEB) void'(win[b].pop_front());
        all_diff = (win[b].size() == DEB);
        foreach (win[b][k]) if (win[b][k] == m_db[b]) all_diff = 0;
        if (all_diff) begin
          m_db[b]  = ~m_db[b];
          nrise[b] = m_db[b];
        end
      end
      m_rise = nrise;
      m_r2   = m_r1;
      m_r1   = btn;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] exp);
    n_vec++;
    if (LED !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: LED=%02h expected=%02h", tag, $time, LED, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge(RESET, BTN);
    #1;
    check("model", m_led);
  endtask

  task automatic add(input logic rst, input logic [3:0] btn, input int ncyc, input logic [7:0] exp);
    vec_t v;
    v.rst = rst; v.btn = btn; v.ncyc = ncyc; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    int n;
    model_reset();

    // Reset and idle
    add(1, 4'h0, 3, 8'h00);
    add(0, 4'h0, 20, 8'h00);
    // Operand latency: visible exactly 7 cycles after the raw change
    add(0, 4'h3, 6, 8'h00);
    add(0, 4'h3, 1, 8'h31);
    // 2-cycle glitch on A is rejected
    add(0, 4'h2, 2, 8'h31);
    add(0, 4'h3, 10, 8'h31);
    add(0, 4'h1, 10, 8'h10);
    // Six mode steps with A=1,B=0
    add(0, 4'h5, 8, 8'h93); add(0, 4'h1, 8, 8'h93);
    add(0, 4'h5, 8, 8'h15); add(0, 4'h1, 8, 8'h15);
    add(0, 4'h5, 8, 8'h97); add(0, 4'h1, 8, 8'h97);
    add(0, 4'h5, 8, 8'h18); add(0, 4'h1, 8, 8'h18);
    add(0, 4'h5, 8, 8'h9A); add(0, 4'h1, 8, 8'h9A);
    add(0, 4'h5, 8, 8'h10); add(0, 4'h1, 8, 8'h10);
    // Sweep in AND with a second demo press mid-sweep
    add(0, 4'h9, 8, 8'h40);
    add(0, 4'h1, 8, 8'h50);
    add(0, 4'h9, 8, 8'h60);
    add(0, 4'h1, 8, 8'h71);
    add(0, 4'h1, 8, 8'h10);
    // Mode step and demo together, then a step at op_cnt=2
    add(0, 4'hD, 8, 8'hC2);
    add(0, 4'h1, 8, 8'hD3);
    add(0, 4'h5, 8, 8'h65);
    add(0, 4'h1, 8, 8'h74);
    add(0, 4'h1, 8, 8'h15);
    // Reset mid-sweep with demo held, then a fresh sweep
    add(0, 4'h9, 8, 8'h44);
    add(1, 4'h9, 1, 8'h00);
    add(0, 4'h9, 8, 8'h40);
    add(0, 4'h1, 40, 8'h10);

    foreach (tbl[i]) begin
      RESET = tbl[i].rst;
      BTN   = tbl[i].btn;
      repeat (tbl[i].ncyc) tick();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    for (int r = 0; r < 700; r++) begin
      RESET = ($urandom_range(0, 59) == 0);
      BTN   = 4'($urandom_range(0, 15));
      n     = $urandom_range(1, 12);
      repeat (n) tick();
    end
    RESET = 1'b0;
    BTN   = 4'h0;
    repeat (60) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
